// File: rtl/cpu_pkg.sv
// Shared CPU-side types and constants.
// Memory arbiter widths, port indices and FSM state encoding.
package cpu_pkg;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int NREQ = 3;

  localparam logic [1:0] PORT_FETCH = 2'd0;
  localparam logic [1:0] PORT_DATA  = 2'd1;
  localparam logic [1:0] PORT_DEBUG = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  function automatic logic [1:0] oh2idx(
    input logic [NREQ-1:0] oh
  );
    logic [1:0] idx;
    idx = PORT_FETCH;
    if (oh[PORT_DATA])  idx = PORT_DATA;
    if (oh[PORT_DEBUG]) idx = PORT_DEBUG;
    return idx;
  endfunction

  function automatic logic [NREQ-1:0] idx2oh(
    input logic [1:0] idx
  );
    logic [NREQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NREQ; i++)
      oh[i] = (idx == i[1:0]);
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick over the three requesters.
// Search starts at the port after the last accepted one.
module rr_pick
  import cpu_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last_gnt,
  output logic            valid,
  output logic [NREQ-1:0] grant
);

  logic [1:0] first;
  logic [1:0] second;
  logic [1:0] third;

  // Rotate priority order, then take the first pending port
  always_comb begin
    first  = PORT_FETCH;
    second = PORT_DATA;
    third  = PORT_DEBUG;
    case (last_gnt)
      PORT_FETCH: begin
        first  = PORT_DATA;
        second = PORT_DEBUG;
        third  = PORT_FETCH;
      end
      PORT_DATA: begin
        first  = PORT_DEBUG;
        second = PORT_FETCH;
        third  = PORT_DATA;
      end
      default: ;
    endcase
    grant = '0;
    if (req[first])
      grant = idx2oh(first);
    else if (req[second])
      grant = idx2oh(second);
    else if (req[third])
      grant = idx2oh(third);
    valid = |req;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-port single-memory arbiter.
// IDLE picks and latches, ACCESS drives memory, RESP returns read data.
module mem_arbiter #(
  parameter int AW   = cpu_pkg::AW,
  parameter int DW   = cpu_pkg::DW,
  parameter int NREQ = cpu_pkg::NREQ
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata,
  output logic               busy
);
  import cpu_pkg::*;

  arb_state_t    state_q, state_d;
  logic [1:0]    last_q, last_d;
  logic [1:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic            pick_valid;
  logic [NREQ-1:0] pick_oh;
  logic [1:0]      pick_idx;

  rr_pick u_pick (
    .req      (req),
    .last_gnt (last_q),
    .valid    (pick_valid),
    .grant    (pick_oh)
  );

  assign pick_idx = oh2idx(pick_oh);

  // State and latched request; last grant starts at debug so fetch wins first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= PORT_DEBUG;
      sel_q   <= PORT_FETCH;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state, request latch and per-state outputs
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    gnt     = '0;
    rvalid  = '0;
    rdata   = '0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ACCESS;
          sel_d   = pick_idx;
          last_d  = pick_idx;
          we_d    = req_we[pick_idx];
          addr_d  = req_addr[pick_idx*AW +: AW];
          wdata_d = req_wdata[pick_idx*DW +: DW];
        end
      end
      ACCESS: begin
        gnt     = idx2oh(sel_q);
        mem_we  = we_q;
        state_d = we_q ? IDLE : RESP;
      end
      RESP: begin
        rvalid  = idx2oh(sel_q);
        rdata   = mem_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// Drives and samples on the falling edge; memory model is a sync RAM.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  req_we;
  logic [47:0] req_addr;
  logic [47:0] req_wdata;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [15:0] rdata;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  int checks;
  int failures;

  logic [15:0] mem [0:65535];
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en)
      mem[ld_addr] <= ld_data;
    else if (mem_we)
      mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic set_port(input int p, input logic we,
                          input logic [15:0] a, input logic [15:0] d);
    req_we[p] = we;
    req_addr[p*16 +: 16] = a;
    req_wdata[p*16 +: 16] = d;
  endtask

  function automatic int idx_of(input logic [2:0] oh);
    if (oh[2]) return 2;
    if (oh[1]) return 1;
    return 0;
  endfunction

  task automatic test_reset;
    reset = 1'b0;
    req = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    @(negedge clk);
    load(16'h0010, 16'h1234);
    load(16'h0100, 16'hA000);
    load(16'h0101, 16'hA001);
    load(16'h0102, 16'hA002);
    load(16'h0030, 16'h5A5A);
    load(16'h0040, 16'hC3C3);
    load(16'h0050, 16'h0000);
    checks++;
    if ({gnt, rvalid} !== 6'b0) begin
      failures++;
      $display("FAIL reset_gnt_rvalid got=%b exp=000000", {gnt, rvalid});
    end
    checks++;
    if ({rdata, mem_addr, mem_wdata} !== 48'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {rdata, mem_addr, mem_wdata});
    end
    checks++;
    if ({mem_we, busy} !== 2'b00) begin
      failures++;
      $display("FAIL reset_we_busy got=%b exp=00", {mem_we, busy});
    end
    reset = 1'b1;
  endtask

  task automatic test_read;
    set_port(0, 1'b0, 16'h0010, 16'h0);
    req = 3'b001;
    #1;
    checks++;
    if ({gnt, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL read_c1 got=%b exp=0000", {gnt, busy});
    end
    @(negedge clk);
    checks++;
    if ({gnt, mem_we, busy} !== 5'b00101 || mem_addr !== 16'h0010) begin
      failures++;
      $display("FAIL read_c2 got=%b/%h exp=00101/0010", {gnt, mem_we, busy}, mem_addr);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (rvalid !== 3'b001 || gnt !== 3'b000 || rdata !== 16'h1234) begin
      failures++;
      $display("FAIL read_c3 got=%b/%b/%h exp=001/000/1234", rvalid, gnt, rdata);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rvalid !== 3'b000 || mem_addr !== 16'h0010) begin
      failures++;
      $display("FAIL read_c4 got=%b/%b/%h exp=0/000/0010", busy, rvalid, mem_addr);
    end
  endtask

  task automatic test_write;
    int we_cnt;
    we_cnt = 0;
    set_port(1, 1'b1, 16'h0020, 16'hBEEF);
    req = 3'b010;
    @(negedge clk);
    we_cnt += int'(mem_we);
    checks++;
    if (gnt !== 3'b010 || mem_we !== 1'b1 || mem_addr !== 16'h0020 || mem_wdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL write_access got=%b/%b/%h/%h exp=010/1/0020/beef", gnt, mem_we, mem_addr, mem_wdata);
    end
    req = '0;
    @(negedge clk);
    we_cnt += int'(mem_we);
    checks++;
    if (busy !== 1'b0 || mem_wdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL write_done got=%b/%h exp=0/beef", busy, mem_wdata);
    end
    set_port(1, 1'b0, 16'h0020, 16'h0);
    req = 3'b010;
    @(negedge clk);
    we_cnt += int'(mem_we);
    req = '0;
    @(negedge clk);
    we_cnt += int'(mem_we);
    checks++;
    if (rvalid !== 3'b010 || rdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL write_readback got=%b/%h exp=010/beef", rvalid, rdata);
    end
    @(negedge clk);
    we_cnt += int'(mem_we);
    checks++;
    if (we_cnt !== 1) begin
      failures++;
      $display("FAIL write_we_pulses got=%0d exp=1", we_cnt);
    end
  endtask

  task automatic test_rotation;
    int gq[$];
    int rq[$];
    int bad;
    int exp_seq[6];
    exp_seq = '{0, 1, 2, 0, 1, 2};
    bad = 0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int p = 0; p < 3; p++)
      set_port(p, 1'b0, 16'h0100 + 16'(p), 16'h0);
    req = 3'b111;
    for (int i = 0; i < 18; i++) begin
      #1;
      if ($countones(gnt) > 1 || $countones(rvalid) > 1) bad++;
      if (gnt != 0 && rvalid != 0) bad++;
      if (gnt != 0) gq.push_back(idx_of(gnt));
      if (rvalid != 0) begin
        rq.push_back(idx_of(rvalid));
        if (rdata !== 16'hA000 + 16'(idx_of(rvalid))) bad++;
      end
      if (i == 17) req = '0;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL rot_onehot_data got=%0d exp=0", bad);
    end
    checks++;
    if (gq.size() !== 6 || rq.size() !== 6) begin
      failures++;
      $display("FAIL rot_counts got=%0d/%0d exp=6/6", gq.size(), rq.size());
    end
    for (int k = 0; k < 6; k++) begin
      if (k < gq.size() && k < rq.size()) begin
        checks++;
        if (gq[k] !== exp_seq[k] || rq[k] !== exp_seq[k]) begin
          failures++;
          $display("FAIL rot_order[%0d] got=%0d/%0d exp=%0d", k, gq[k], rq[k], exp_seq[k]);
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rot_idle got=%b exp=0", busy);
    end
  endtask

  task automatic test_busy_arrival;
    set_port(0, 1'b0, 16'h0030, 16'h0);
    req = 3'b001;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    set_port(2, 1'b0, 16'h0040, 16'h0);
    req = 3'b100;
    #1;
    checks++;
    if (rvalid !== 3'b001 || rdata !== 16'h5A5A) begin
      failures++;
      $display("FAIL arr_p0_data got=%b/%h exp=001/5a5a", rvalid, rdata);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 3'b000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL arr_idle got=%b/%b exp=000/0", gnt, busy);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 3'b100 || mem_addr !== 16'h0040) begin
      failures++;
      $display("FAIL arr_p2_gnt got=%b/%h exp=100/0040", gnt, mem_addr);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (rvalid !== 3'b100 || rdata !== 16'hC3C3) begin
      failures++;
      $display("FAIL arr_p2_data got=%b/%h exp=100/c3c3", rvalid, rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int seen;
    seen = 0;
    set_port(1, 1'b1, 16'h0050, 16'h1111);
    req = 3'b010;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || gnt !== 3'b010) begin
      failures++;
      $display("FAIL abort_access got=%b/%b exp=1/010", mem_we, gnt);
    end
    #2;
    reset = 1'b0;
    req = '0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || gnt !== 3'b000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_async got=%b/%b/%b exp=0/000/0", mem_we, gnt, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (gnt != 0 || rvalid != 0 || mem_we) seen++;
    end
    checks++;
    if (seen !== 0 || mem[16'h0050] !== 16'h0000) begin
      failures++;
      $display("FAIL abort_quiet got=%0d/%h exp=0/0000", seen, mem[16'h0050]);
    end
    for (int p = 0; p < 3; p++)
      set_port(p, 1'b0, 16'h0100 + 16'(p), 16'h0);
    req = 3'b111;
    @(negedge clk);
    checks++;
    if (gnt !== 3'b001) begin
      failures++;
      $display("FAIL abort_first_gnt got=%b exp=001", gnt);
    end
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_read();
    test_write();
    test_rotation();
    test_busy_arrival();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
